// File: rtl/bingo_grid_scanner.sv
// Raster-to-cell coordinate scanner for the 5x5 Bingo board window.
// Stage 1 addresses the window/number BRAMs; stage 2 lines up with their read data.
module bingo_grid_scanner #(
  parameter int GRID_X0 = 80,
  parameter int GRID_Y0 = 0,
  parameter int BLOCK_W = 96,
  parameter int N_CELL  = 5
) (
  input  logic                        clk_25MHz,
  input  logic                        all_rst,
  input  logic [9:0]                  h_cnt,
  input  logic [9:0]                  v_cnt,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic [5*N_CELL*N_CELL-1:0]  map,
  input  logic [2:0]                  cursor_x,
  input  logic [2:0]                  cursor_y,
  output logic [2:0]                  block_x,
  output logic [2:0]                  block_y,
  output logic [6:0]                  pixel_x,
  output logic [6:0]                  pixel_y,
  output logic                        in_grid,
  output logic [4:0]                  cell_num,
  output logic                        is_cursor,
  output logic                        hsync_out,
  output logic                        vsync_out
);

  localparam int STAGES = 2;
  localparam int NC     = N_CELL * N_CELL;
  localparam int IW     = $clog2(NC) + 1;
  localparam logic [9:0] X0   = 10'(GRID_X0);
  localparam logic [9:0] Y0   = 10'(GRID_Y0);
  localparam logic [9:0] SPAN = 10'(N_CELL * BLOCK_W);
  localparam logic [6:0] PMAX = 7'(BLOCK_W - 1);

  logic [9:0]             h_off, v_off;
  logic                   in_x, in_y;
  logic [STAGES:1]        vld_pipe;
  logic [STAGES:1][1:0]   sync_pipe;
  logic [IW-1:0]          idx;
  logic [4:0]             cell_sel;

  // Offset compare folds the lower bound into the unsigned wrap.
  assign h_off = h_cnt - X0;
  assign v_off = v_cnt - Y0;
  assign in_x  = h_off < SPAN;
  assign in_y  = v_off < SPAN;

  assign idx = IW'(block_y) * IW'(N_CELL) + IW'(block_x);

  always_comb begin
    cell_sel = '0;
    for (int k = 0; k < NC; k++)
      if (idx == IW'(k)) cell_sel = map[5*k +: 5];
  end

  always_ff @(posedge clk_25MHz) begin
    if (!all_rst) begin
      pixel_x   <= '0;
      block_x   <= '0;
      pixel_y   <= '0;
      block_y   <= '0;
      vld_pipe  <= '0;
      sync_pipe <= '0;
      cell_num  <= '0;
      is_cursor <= 1'b0;
    end else begin
      if (!in_x || h_cnt == X0) begin
        pixel_x <= '0;
        block_x <= '0;
      end else if (pixel_x == PMAX) begin
        pixel_x <= '0;
        block_x <= block_x + 3'd1;
      end else begin
        pixel_x <= pixel_x + 7'd1;
      end

      // Vertical state advances once per line, on the h_cnt==0 cycle.
      if (h_cnt == '0) begin
        if (v_cnt == Y0 || !in_y) begin
          pixel_y <= '0;
          block_y <= '0;
        end else if (pixel_y == PMAX) begin
          pixel_y <= '0;
          block_y <= block_y + 3'd1;
        end else begin
          pixel_y <= pixel_y + 7'd1;
        end
      end

      vld_pipe[1]  <= in_x && in_y;
      vld_pipe[2]  <= vld_pipe[1];
      sync_pipe[1] <= {hsync_in, vsync_in};
      sync_pipe[2] <= sync_pipe[1];
      cell_num     <= vld_pipe[1] ? cell_sel : '0;
      is_cursor    <= vld_pipe[1] && block_x == cursor_x && block_y == cursor_y;
    end
  end

  assign in_grid   = vld_pipe[STAGES];
  assign hsync_out = sync_pipe[STAGES][1];
  assign vsync_out = sync_pipe[STAGES][0];

endmodule

// File: tb/tb_bingo_grid_scanner.sv
// Bench for bingo_grid_scanner: arithmetic raster model (mod/div of the counters)
// compared every cycle, plus hand-computed pins at the board boundaries.
module tb_bingo_grid_scanner;

  logic         clk_25MHz = 1'b0;
  logic         all_rst   = 1'b0;
  logic [9:0]   h_cnt     = 10'd95;
  logic [9:0]   v_cnt     = 10'd524;
  logic         hsync_in  = 1'b0;
  logic         vsync_in  = 1'b0;
  logic [124:0] map       = '0;
  logic [2:0]   cursor_x  = '0;
  logic [2:0]   cursor_y  = '0;
  logic [2:0]   block_x, block_y;
  logic [6:0]   pixel_x, pixel_y;
  logic         in_grid, is_cursor, hsync_out, vsync_out;
  logic [4:0]   cell_num;

  bingo_grid_scanner dut (
    .clk_25MHz(clk_25MHz), .all_rst(all_rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .map(map),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .block_x(block_x), .block_y(block_y), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .in_grid(in_grid), .cell_num(cell_num), .is_cursor(is_cursor),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  int total = 0, bad = 0, phase = 0;
  bit started = 1'b0;

  // Model of the board geometry: 80 + 5*96 columns, 0 + 5*96 rows.
  function automatic bit inx(input int h); return h >= 80 && h < 560; endfunction
  function automatic bit iny(input int v); return v >= 0 && v < 480; endfunction
  function automatic int epx(input int h); return inx(h) ? (h - 80) % 96 : 0; endfunction
  function automatic int ebx(input int h); return inx(h) ? (h - 80) / 96 : 0; endfunction
  function automatic int epy(input int v); return iny(v) ? v % 96 : 0; endfunction
  function automatic int eby(input int v); return iny(v) ? v / 96 : 0; endfunction
  function automatic int ment(input int k); return int'(map[5*k +: 5]); endfunction
  function automatic bit hok_f(input bit r, input int h, input int p, input bit ok);
    if (!r) return 1'b0;
    if (h == 80) return 1'b1;
    if (h != (p + 1) % 800) return 1'b0;
    return ok;
  endfunction

  int ph = 0;
  bit hok = 0, vok = 0;
  int e_px = 0, e_bx = 0, e_py = 0, e_by = 0, e1_h = 0, e1_v = 0, e2_h = 0, e2_v = 0;
  int e_cell = 0;
  bit e_hchk = 0, e_vchk = 0, e_in1 = 0, e_in2 = 0, e_cur = 0, e_cchk = 0;
  bit hs1 = 0, hs2 = 0, vs1 = 0, vs2 = 0;

  always @(posedge clk_25MHz) begin
    ph     <= int'(h_cnt);
    hok    <= hok_f(all_rst, int'(h_cnt), ph, hok);
    vok    <= all_rst && ((h_cnt == '0 && v_cnt == '0) || vok);
    e_hchk <= !all_rst || !inx(int'(h_cnt)) || hok_f(all_rst, int'(h_cnt), ph, hok);
    e_px   <= all_rst ? epx(int'(h_cnt)) : 0;
    e_bx   <= all_rst ? ebx(int'(h_cnt)) : 0;
    if (!all_rst) begin
      e_py <= 0;
      e_by <= 0;
    end else if (h_cnt == '0) begin
      e_py <= epy(int'(v_cnt));
      e_by <= eby(int'(v_cnt));
    end
    e_vchk <= !all_rst || (h_cnt == '0 && v_cnt == '0) || vok;
    e_in1  <= all_rst && inx(int'(h_cnt)) && iny(int'(v_cnt));
    e1_h   <= int'(h_cnt);
    e1_v   <= int'(v_cnt);
    e_in2  <= all_rst && e_in1;
    e_cell <= (all_rst && e_in1) ? ment(5 * e_by + e_bx) : 0;
    e_cur  <= all_rst && e_in1 && e_bx == int'(cursor_x) && e_by == int'(cursor_y);
    e_cchk <= !all_rst || !e_in1 || (e_hchk && e_vchk);
    e2_h   <= e1_h;
    e2_v   <= e1_v;
    hs1 <= all_rst && hsync_in;
    hs2 <= all_rst && hs1;
    vs1 <= all_rst && vsync_in;
    vs2 <= all_rst && vs1;
  end

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (h=%0d v=%0d)", nm, got, exp, e1_h, e1_v);
    end
  endtask

  always @(negedge clk_25MHz) begin
    if (started) begin
      if (e_hchk) begin
        chk("pixel_x", int'(pixel_x), e_px);
        chk("block_x", int'(block_x), e_bx);
      end
      if (e_vchk) begin
        chk("pixel_y", int'(pixel_y), e_py);
        chk("block_y", int'(block_y), e_by);
      end
      chk("in_grid", int'(in_grid), int'(e_in2));
      chk("hsync_out", int'(hsync_out), int'(hs2));
      chk("vsync_out", int'(vsync_out), int'(vs2));
      if (e_cchk) begin
        chk("cell_num", int'(cell_num), e_cell);
        chk("is_cursor", int'(is_cursor), int'(e_cur));
      end
      // Hand-computed pins
      if (phase == 0 && e1_h >= 200 && e1_h <= 202) begin
        chk("pin_rst_px", int'(pixel_x), 0);
        chk("pin_rst_bx", int'(block_x), 0);
        chk("pin_rst_in_grid", int'(in_grid), 0);
        chk("pin_rst_hsync", int'(hsync_out), 0);
        chk("pin_rst_vsync", int'(vsync_out), 0);
      end
      if (phase == 1) begin
        if (e1_h == 80)  begin chk("pin_h80_px", int'(pixel_x), 0);   chk("pin_h80_bx", int'(block_x), 0); end
        if (e1_h == 175) begin chk("pin_h175_px", int'(pixel_x), 95); chk("pin_h175_bx", int'(block_x), 0); end
        if (e1_h == 176) begin chk("pin_h176_px", int'(pixel_x), 0);  chk("pin_h176_bx", int'(block_x), 1); end
        if (e1_h == 559) begin chk("pin_h559_px", int'(pixel_x), 95); chk("pin_h559_bx", int'(block_x), 4); end
        if (e1_h == 560) begin chk("pin_h560_px", int'(pixel_x), 0);  chk("pin_h560_bx", int'(block_x), 0); end
        if (e2_h == 559) chk("pin_h559_in_grid", int'(in_grid), 1);
        if (e2_h == 560) chk("pin_h560_in_grid", int'(in_grid), 0);
      end
      if (phase == 2 && e1_h == 1) begin
        if (e1_v == 95)  begin chk("pin_v95_py", int'(pixel_y), 95); chk("pin_v95_by", int'(block_y), 0); end
        if (e1_v == 96)  begin chk("pin_v96_py", int'(pixel_y), 0);  chk("pin_v96_by", int'(block_y), 1); end
        if (e1_v == 479) begin chk("pin_v479_py", int'(pixel_y), 95); chk("pin_v479_by", int'(block_y), 4); end
        if (e1_v == 480) begin chk("pin_v480_py", int'(pixel_y), 0); chk("pin_v480_by", int'(block_y), 0); end
      end
      if (phase == 2 && e2_h == 82) begin
        if (e2_v == 479) chk("pin_v479_in_grid", int'(in_grid), 1);
        if (e2_v == 480) chk("pin_v480_in_grid", int'(in_grid), 0);
      end
      if (phase == 3 && e2_v == 197) begin
        if (e2_h == 378) begin
          chk("pin_cell_22", int'(cell_num), 22);
          chk("pin_cell_in_grid", int'(in_grid), 1);
          chk("pin_cursor_in", int'(is_cursor), 1);
        end
        if (e2_h == 463) chk("pin_cursor_last", int'(is_cursor), 1);
        if (e2_h == 464) chk("pin_cursor_next", int'(is_cursor), 0);
      end
      if (phase == 4 && e1_v == 401 && e1_h == 176) begin
        chk("pin_jump_px", int'(pixel_x), 0);
        chk("pin_jump_bx", int'(block_x), 1);
      end
      if (phase == 4 && e2_v == 401 && e2_h == 181) chk("pin_cursor_14", int'(is_cursor), 1);
    end
  end

  task automatic tick(input int h, input int v);
    @(posedge clk_25MHz);
    #1;
    h_cnt    = 10'(h);
    v_cnt    = 10'(v);
    hsync_in = 1'($urandom);
    vsync_in = 1'($urandom);
  endtask

  task automatic rand_map();
    for (int k = 0; k < 25; k++) map[5*k +: 5] = 5'($urandom_range(1, 25));
  endtask

  initial begin
    started = 1'b1;
    rand_map();
    // Power-up reset for 3 edges, then a mid-line reset at h_cnt=200..202.
    for (int h = 96; h < 800; h++) begin
      tick(h, 524);
      all_rst = !(h <= 97 || (h >= 200 && h <= 202));
    end
    phase = 1;
    for (int h = 0; h < 800; h++) tick(h, 0);
    // Abbreviated lines: every line still presents h_cnt==0 for the vertical step.
    phase = 2;
    for (int v = 1; v < 525; v++) begin
      tick(0, v); tick(1, v); tick(2, v);
      for (int h = 78; h <= 84; h++) tick(h, v);
    end
    phase = 3;
    for (int v = 0; v < 197; v++) begin tick(0, v); tick(1, v); end
    rand_map();
    map[65 +: 5] = 5'd22;
    cursor_x = 3'd3;
    cursor_y = 3'd2;
    for (int h = 0; h < 800; h++) tick(h, 197);
    for (int v = 198; v < 400; v++) begin tick(0, v); tick(1, v); end
    cursor_x = 3'd1;
    cursor_y = 3'd4;
    phase = 4;
    for (int h = 0; h <= 300; h++) tick(h, 400);
    for (int h = 0; h < 800; h++) begin
      tick(h, 401);
      if (h == 400) rand_map();
    end
    tick(0, 402); tick(1, 402); tick(2, 402);
    @(posedge clk_25MHz);
    #1;
    phase = 5;
    started = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
